// File: rtl/rgb_to_gray_pipe_pkg.sv
// Shared definitions for the RGB-to-gray converter and the filter stages
// that must line up with its output.
package rgb_to_gray_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_WEIGHTED = 2'd0,
    MODE_R        = 2'd1,
    MODE_G        = 2'd2,
    MODE_B        = 2'd3
  } gray_mode_e;

  // Clocks from an input pixel to its gray value; downstream sync alignment uses this.
  localparam int GRAY_LATENCY = 3;

  function automatic logic vsync_active(input logic vs, input logic pol);
    return (vs == pol);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Generic asynchronous-reset shift register used to carry video sync/enable
// bits alongside a fixed-latency datapath.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB to grayscale converter with fixed-point luma weights,
// frame-synchronous channel-select mode and a matched sync delay line.
module rgb_to_gray_pipe
  import rgb_to_gray_pipe_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int COEF_W = 8,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29,
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_in,
  input  logic              rgb_hsync,
  input  logic              rgb_vsync,
  input  logic              rgb_de,
  input  logic [3*CH_W-1:0] rgb_data,
  output logic              gray_hsync,
  output logic              gray_vsync,
  output logic              gray_de,
  output logic [CH_W-1:0]   gray_data,
  output logic [3*CH_W-1:0] gray_rgb,
  output logic [1:0]        mode_active
);

  localparam int PW = CH_W + COEF_W + 1;
  localparam int SW = CH_W + COEF_W + 3;
  localparam logic [PW-1:0] CR = PW'((COEF_W+1)'(COEF_R));
  localparam logic [PW-1:0] CG = PW'((COEF_W+1)'(COEF_G));
  localparam logic [PW-1:0] CB = PW'((COEF_W+1)'(COEF_B));
  localparam logic [SW-1:0] ROUND = SW'(1) << (COEF_W - 1);
  localparam logic [SW-1:0] Y_MAX = SW'((1 << CH_W) - 1);

  // rgb_de is a valid qualifier with no back-pressure: every cycle advances.
  logic [CH_W-1:0] r_in, g_in, b_in;
  assign {r_in, g_in, b_in} = rgb_data;

  logic            vs_prev_q, vs_prev_d;
  gray_mode_e      mode_active_q, mode_active_d;
  logic            vs_edge;

  logic [PW-1:0]   pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic [CH_W-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic            de1_q, de1_d;
  gray_mode_e      mode1_q, mode1_d;

  logic [SW-1:0]   sum_q, sum_d;
  logic [CH_W-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic            de2_q, de2_d;
  gray_mode_e      mode2_q, mode2_d;

  logic [SW-1:0]   y_full;
  logic [CH_W-1:0] y_sat;
  logic [CH_W-1:0] gray_q, gray_d;

  always_comb begin
    vs_prev_d     = rgb_vsync;
    vs_edge       = vsync_active(rgb_vsync, VS_POL) && !vsync_active(vs_prev_q, VS_POL);
    mode_active_d = vs_edge ? gray_mode_e'(mode_in) : mode_active_q;

    // S1 takes the next mode so a pixel on the vsync edge already uses it.
    pr_d    = PW'(r_in) * CR;
    pg_d    = PW'(g_in) * CG;
    pb_d    = PW'(b_in) * CB;
    r1_d    = r_in;
    g1_d    = g_in;
    b1_d    = b_in;
    de1_d   = rgb_de;
    mode1_d = mode_active_d;

    sum_d   = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + ROUND;
    r2_d    = r1_q;
    g2_d    = g1_q;
    b2_d    = b1_q;
    de2_d   = de1_q;
    mode2_d = mode1_q;

    // Weights summing above 1.0 can push the result past full scale.
    y_full  = sum_q >> COEF_W;
    y_sat   = (y_full > Y_MAX) ? Y_MAX[CH_W-1:0] : y_full[CH_W-1:0];

    gray_d = y_sat;
    case (mode2_q)
      MODE_R:  gray_d = r2_q;
      MODE_G:  gray_d = g2_q;
      MODE_B:  gray_d = b2_q;
      default: gray_d = y_sat;
    endcase
    if (!de2_q) gray_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q     <= 1'b0;
      mode_active_q <= MODE_WEIGHTED;
      pr_q          <= '0;
      pg_q          <= '0;
      pb_q          <= '0;
      r1_q          <= '0;
      g1_q          <= '0;
      b1_q          <= '0;
      de1_q         <= 1'b0;
      mode1_q       <= MODE_WEIGHTED;
      sum_q         <= '0;
      r2_q          <= '0;
      g2_q          <= '0;
      b2_q          <= '0;
      de2_q         <= 1'b0;
      mode2_q       <= MODE_WEIGHTED;
      gray_q        <= '0;
    end else begin
      vs_prev_q     <= vs_prev_d;
      mode_active_q <= mode_active_d;
      pr_q          <= pr_d;
      pg_q          <= pg_d;
      pb_q          <= pb_d;
      r1_q          <= r1_d;
      g1_q          <= g1_d;
      b1_q          <= b1_d;
      de1_q         <= de1_d;
      mode1_q       <= mode1_d;
      sum_q         <= sum_d;
      r2_q          <= r2_d;
      g2_q          <= g2_d;
      b2_q          <= b2_d;
      de2_q         <= de2_d;
      mode2_q       <= mode2_d;
      gray_q        <= gray_d;
    end
  end

  logic [2:0] sync_out;

  sync_delay #(
    .WIDTH(3),
    .DEPTH(GRAY_LATENCY)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  ({rgb_hsync, rgb_vsync, rgb_de}),
    .d_out (sync_out)
  );

  assign {gray_hsync, gray_vsync, gray_de} = sync_out;
  assign gray_data   = gray_q;
  assign gray_rgb    = {gray_q, gray_q, gray_q};
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Bench for rgb_to_gray_pipe: default-weight and saturating-weight instances
// share stimulus and are compared against a per-pixel arithmetic model.
module tb_rgb_to_gray_pipe;

  localparam int EW = 22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode_in = 2'd0;
  logic        rgb_hsync = 1'b0, rgb_vsync = 1'b0, rgb_de = 1'b0;
  logic [23:0] rgb_data = '0;

  logic        g_hs, g_vs, g_de, s_hs, s_vs, s_de;
  logic [7:0]  g_data, s_data;
  logic [23:0] g_rgb, s_rgb;
  logic [1:0]  g_mode, s_mode;

  always #5 clk = ~clk;

  rgb_to_gray_pipe dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in),
    .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync), .rgb_de(rgb_de), .rgb_data(rgb_data),
    .gray_hsync(g_hs), .gray_vsync(g_vs), .gray_de(g_de),
    .gray_data(g_data), .gray_rgb(g_rgb), .mode_active(g_mode)
  );

  rgb_to_gray_pipe #(.COEF_R(128), .COEF_G(128), .COEF_B(128)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in),
    .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync), .rgb_de(rgb_de), .rgb_data(rgb_data),
    .gray_hsync(s_hs), .gray_vsync(s_vs), .gray_de(s_de),
    .gray_data(s_data), .gray_rgb(s_rgb), .mode_active(s_mode)
  );

  // Scoreboard: {g_hs,g_vs,g_de,s_hs,s_vs,s_de,g_data,s_data} per cycle
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [1:0]    m_mode = 2'd0;
  logic          m_vs_prev = 1'b0;

  typedef struct {
    int r; int g; int b; int exp_w; int exp_s;
  } vec_t;
  vec_t tab[6];

  function automatic int ref_gray(int r, int g, int b, int mode, int de,
                                  int cr, int cg, int cb);
    int y;
    if (de == 0) return 0;
    case (mode)
      1: return r;
      2: return g;
      3: return b;
      default: begin
        y = (r * cr + g * cg + b * cb + 128) / 256;
        return (y > 255) ? 255 : y;
      end
    endcase
  endfunction

  task automatic check_eq(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_now();
    logic [EW-1:0] e, a;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    a = {g_hs, g_vs, g_de, s_hs, s_vs, s_de, g_data, s_data};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL pipe_out got %h expected %h", a, e);
    end
    checks++;
    if (g_rgb !== {3{e[15:8]}} || s_rgb !== {3{e[7:0]}}) begin
      errors++;
      $display("FAIL gray_rgb got %h/%h expected %h/%h", g_rgb, s_rgb, {3{e[15:8]}}, {3{e[7:0]}});
    end
    checks++;
    if (g_mode !== m_mode || s_mode !== m_mode) begin
      errors++;
      $display("FAIL mode_active got %0d/%0d expected %0d", g_mode, s_mode, m_mode);
    end
    if (g_de === 1'b0) check_eq("blank_zero", int'(g_data), 0);
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de,
                       input int r, input int g, input int b, input logic [1:0] mode);
    int gy, sy;
    rgb_hsync = hs;
    rgb_vsync = vs;
    rgb_de    = de;
    rgb_data  = {8'(r), 8'(g), 8'(b)};
    mode_in   = mode;
    if (vs && !m_vs_prev) m_mode = mode;
    m_vs_prev = vs;
    gy = ref_gray(r, g, b, int'(m_mode), int'(de), 77, 150, 29);
    sy = ref_gray(r, g, b, int'(m_mode), int'(de), 128, 128, 128);
    exp_q.push_back({hs, vs, de, hs, vs, de, 8'(gy), 8'(sy)});
  endtask

  task automatic cycle(input logic hs, input logic vs, input logic de,
                       input int r, input int g, input int b, input logic [1:0] mode);
    @(negedge clk);
    check_now();
    drive(hs, vs, de, r, g, b, mode);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, mode_in);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    m_mode    = 2'd0;
    m_vs_prev = 1'b0;
    check_now();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'd0);
  endtask

  // Pixel driven now, fixed expectation checked exactly three clocks later.
  task automatic pixel_check(input string name, input logic vs, input int r, input int g,
                             input int b, input logic [1:0] mode, input int exp_w, input int exp_s);
    cycle(1'b0, vs, 1'b1, r, g, b, mode);
    repeat (3) idle();
    check_eq({name, "_w"}, int'(g_data), exp_w);
    check_eq({name, "_s"}, int'(s_data), exp_s);
  endtask

  initial begin
    tab[0] = '{255, 255, 255, 255, 255};
    tab[1] = '{0, 0, 0, 0, 0};
    tab[2] = '{100, 150, 200, 141, 225};
    tab[3] = '{10, 20, 30, 18, 30};
    tab[4] = '{255, 0, 0, 77, 128};
    tab[5] = '{0, 0, 255, 29, 128};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_data", int'(g_data), 0);
    check_eq("rst_rgb", int'(g_rgb != 0), 0);
    check_eq("rst_sync", int'({g_hs, g_vs, g_de}), 0);
    check_eq("rst_mode", int'(g_mode), 0);
    reset_release();

    // Directed vectors in weighted mode
    for (int i = 0; i < 6; i++) begin
      pixel_check($sformatf("vec%0d", i), 1'b0, tab[i].r, tab[i].g, tab[i].b, 2'd0,
                  tab[i].exp_w, tab[i].exp_s);
    end

    // Mode request mid-frame is ignored until the next vsync edge
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 2'd0);
    repeat (5) idle();
    pixel_check("mid_frame", 1'b0, 100, 150, 200, 2'd1, 141, 225);
    check_eq("mode_held", int'(g_mode), 0);
    pixel_check("edge_pixel", 1'b1, 100, 150, 200, 2'd1, 100, 100);
    check_eq("mode_new", int'(g_mode), 1);
    pixel_check("after_edge", 1'b0, 30, 60, 90, 2'd0, 30, 30);

    // Random sync/de pattern over a 16x8 frame
    for (int line = 0; line < 8; line++) begin
      for (int col = 0; col < 16; col++) begin
        cycle(1'($urandom_range(0, 1)),
              (line == 0 && col < 2) ? 1'b1 : 1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      end
    end

    // de toggling every cycle
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 1'(i % 2), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), mode_in);
    end

    // Asynchronous reset with the pipeline full and a non-default mode
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'd2);
    cycle(1'b0, 1'b1, 1'b1, 200, 100, 50, 2'd2);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, int'($urandom_range(1, 255)), 77, 99, 2'd2);
    end
    check_eq("pre_rst_mode", int'(g_mode), 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_data", int'(g_data), 0);
    check_eq("arst_sat", int'(s_data), 0);
    check_eq("arst_rgb", int'(g_rgb != 0), 0);
    check_eq("arst_sync", int'({g_hs, g_vs, g_de}), 0);
    check_eq("arst_mode", int'(g_mode), 0);
    rgb_de = 1'b0;
    rgb_vsync = 1'b0;
    rgb_hsync = 1'b0;
    reset_release();
    pixel_check("post_rst", 1'b0, 10, 20, 30, 2'd0, 18, 30);

    // Back-to-back pixels with de held high
    for (int i = 0; i < 1024; i++) begin
      cycle(1'(i % 64 == 0), 1'(i % 256 == 0), 1'b1,
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
